hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
Parametrised hazard and stall controller for the 5-stage ARM pipeline. Detects register read-after-write hazards against the EXE and MEM stages for up to NUM_SRC source operands. Runs in two modes: forwarding mode, where only load-use hazards stall, and stall-only mode. Also tracks memory-wait stalls with a bounded timeout state machine, and drives the IF/ID freeze and the forwarding-mux selects.

Parameters:
REG_AW, 4, register address width
NUM_SRC, 2, number of source operands checked per instruction (1..4)
MAX_WAIT, 16, memory wait cycles tolerated before timeout (>=2)
CNT_W, 5, wait counter width; must satisfy 2^CNT_W > MAX_WAIT

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  synchronous reset, active-low
src_addr  in  NUM_SRC*REG_AW  packed source register numbers; operand i at [i*REG_AW +: REG_AW]
src_valid  in  NUM_SRC  operand i is actually read
exe_dest  in  REG_AW  EXE-stage destination register
exe_wb_en  in  1  EXE-stage instruction writes back
exe_mem_r_en  in  1  EXE-stage instruction is a load
mem_dest  in  REG_AW  MEM-stage destination register
mem_wb_en  in  1  MEM-stage instruction writes back
fwd_en  in  1  1 = forwarding mode, 0 = stall-only mode
mem_r_en  in  1  MEM-stage read request
mem_w_en  in  1  MEM-stage write request
mem_ready  in  1  memory completes the access this cycle
err_clr  in  1  clears the timeout error
hazard  out  1  freeze PC/IF/ID, insert bubble
data_hazard  out  1  register hazard component of hazard
mem_stall  out  1  memory-wait component of hazard
fwd_sel  out  2*NUM_SRC  per-operand mux select: 00 regfile, 01 EXE result, 10 MEM result
mem_timeout  out  1  sticky timeout error, registered
wait_cnt  out  CNT_W  current memory wait-cycle count, registered

Behaviour:
- Per operand i:
  - hit_exe = src_valid[i] & exe_wb_en & (src_i == exe_dest)
  - hit_mem = src_valid[i] & mem_wb_en & (src_i == mem_dest)
- Stall-only mode (fwd_en=0):
  - data_hazard = OR over i of (hit_exe | hit_mem).
  - fwd_sel = all zeros.
- Forwarding mode (fwd_en=1):
  - data_hazard = OR over i of (hit_exe & exe_mem_r_en).
  - fwd_sel[i] = 01 if hit_exe & ~exe_mem_r_en; else 10 if hit_mem; else 00.
  - EXE has priority over MEM.
- data_hazard and fwd_sel are combinational, with zero latency.
- Memory FSM states: IDLE, WAIT, ERR. Let acc = mem_r_en | mem_w_en.
  - IDLE:
    - acc & ~mem_ready -> WAIT, wait_cnt <= 1.
    - Otherwise stay, wait_cnt <= 0.
  - WAIT:
    - mem_ready or ~acc -> IDLE, wait_cnt <= 0.
    - Else if wait_cnt == MAX_WAIT-1 -> ERR, mem_timeout <= 1.
    - Else wait_cnt <= wait_cnt+1.
  - ERR:
    - mem_timeout holds 1, wait_cnt holds its value.
    - err_clr -> IDLE, mem_timeout <= 0, wait_cnt <= 0.
- mem_stall = acc & ~mem_ready & (state != ERR). This is combinational, so the stall begins the same cycle the request appears. In ERR the pipeline is released.
- hazard = data_hazard | mem_stall.
- mem_ready asserted on the first request cycle: no stall, FSM stays IDLE.
- err_clr outside ERR: ignored.
- err_clr and a new unready request in the same ERR cycle: FSM goes to IDLE; WAIT is entered on the next cycle if the request persists.
- rst=0 sampled at a clock edge, in any state:
  - state <= IDLE, wait_cnt <= 0, mem_timeout <= 0.
  - Combinational outputs follow their inputs; they are all 0 when the inputs are 0.
- Address compare uses full REG_AW bits with no register-15 special case. A destination of 0 is a valid match.

Optional Feature:
STALL_STATS_EN.
- Defined:
  - Adds outputs data_stall_cycles [31:0] and mem_stall_cycles [31:0].
  - Each increments on every clock where data_hazard (resp. mem_stall) is 1.
  - Each saturates at 0xFFFFFFFF and is reset to 0 by rst.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. fwd_en=0, src0=3 valid, exe_dest=3, exe_wb_en=1 -> data_hazard=1, hazard=1, fwd_sel=0000. Same with mem_dest=3 only -> hazard=1.
2. fwd_en=1:
   - src0=5, exe_dest=5, exe_wb_en=1, exe_mem_r_en=0 -> hazard=0, fwd_sel[1:0]=01.
   - Set exe_mem_r_en=1 -> hazard=1.
   - src1=7, mem_dest=7, mem_wb_en=1 -> fwd_sel[3:2]=10.
   - Both stages target 5 -> fwd_sel[1:0]=01.
3. mem_r_en=1, mem_ready low 3 cycles then high:
   - mem_stall=1 for 3 cycles; wait_cnt = 1, 2, 3.
   - The ready cycle has mem_stall=0; next cycle wait_cnt=0, mem_timeout=0.
4. MAX_WAIT=16, mem_w_en=1, mem_ready held 0:
   - mem_stall=1 for 16 cycles, then mem_timeout=1, mem_stall=0, wait_cnt=15.
   - Stays there until err_clr=1 for one cycle, then mem_timeout=0, wait_cnt=0.
5. rst=0 asserted while in WAIT with wait_cnt=6 -> after that edge wait_cnt=0, mem_timeout=0, state IDLE. Repeat in ERR -> same.
6. STALL_STATS_EN defined: 4 data-hazard cycles plus 2 mem-stall cycles -> data_stall_cycles=4, mem_stall_cycles=2. Preload near the maximum -> saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller: RAW detection against EXE/MEM, forwarding selects, memory-wait FSM.
// Optional macro STALL_STATS_EN adds saturating stall-cycle counters.
module hazard_stall_ctrl #(
    parameter int REG_AW   = 4,
    parameter int NUM_SRC  = 2,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] src_addr,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [REG_AW-1:0]         exe_dest,
    input  logic                      exe_wb_en,
    input  logic                      exe_mem_r_en,
    input  logic [REG_AW-1:0]         mem_dest,
    input  logic                      mem_wb_en,
    input  logic                      fwd_en,
    input  logic                      mem_r_en,
    input  logic                      mem_w_en,
    input  logic                      mem_ready,
    input  logic                      err_clr,
    output logic                      hazard,
    output logic                      data_hazard,
    output logic                      mem_stall,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      mem_timeout,
    output logic [CNT_W-1:0]          wait_cnt
`ifdef STALL_STATS_EN
    ,
    output logic [31:0]               data_stall_cycles,
    output logic [31:0]               mem_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ERR  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [NUM_SRC-1:0] hit_exe, hit_mem;
    logic               acc;

    assign acc = mem_r_en | mem_w_en;

    // Full-width compare: register 0 is a legitimate destination.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        hit_exe = '0;
        hit_mem = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            hit_exe[i] = src_valid[i] & exe_wb_en & (src_addr[i*REG_AW +: REG_AW] == exe_dest);
            hit_mem[i] = src_valid[i] & mem_wb_en & (src_addr[i*REG_AW +: REG_AW] == mem_dest);
        end
    end

    always_comb begin
        data_hazard = 1'b0;
        fwd_sel     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (fwd_en) begin
                // Only a load in EXE cannot be forwarded in time.
                if (hit_exe[i] & exe_mem_r_en)
                    data_hazard = 1'b1;
                if (hit_exe[i] & ~exe_mem_r_en)
                    fwd_sel[2*i +: 2] = 2'b01;
                else if (hit_mem[i])
                    fwd_sel[2*i +: 2] = 2'b10;
            end else if (hit_exe[i] | hit_mem[i]) begin
                data_hazard = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= cnt_nxt;
            mem_timeout <= (state_nxt == S_ERR);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = wait_cnt;
        case (state)
            S_IDLE: begin
                if (acc & ~mem_ready) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = CNT_W'(1);
                end else begin
                    cnt_nxt   = '0;
                end
            end
            S_WAIT: begin
                if (mem_ready | ~acc) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
                    state_nxt = S_ERR;
                end else begin
                    cnt_nxt   = wait_cnt + CNT_W'(1);
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Output logic: the stall is released once the FSM has given up.
    always_comb begin
        mem_stall = acc & ~mem_ready & (state != S_ERR);
        hazard    = data_hazard | mem_stall;
    end

`ifdef STALL_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            data_stall_cycles <= '0;
            mem_stall_cycles  <= '0;
        end else begin
            if (data_hazard && (data_stall_cycles != '1))
                data_stall_cycles <= data_stall_cycles + 32'd1;
            if (mem_stall && (mem_stall_cycles != '1))
                mem_stall_cycles <= mem_stall_cycles + 32'd1;
        end
    end
`endif

endmodule
